// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle strobes into fixed on/off LED blinks
//
// Each accepted strobe on pulse_in becomes one blink: led_out high for
// ON_CYC cycles, then low for an OFF_CYC gap. Strobes arriving mid-blink
// are queued (up to MAX_PENDING) and replayed back-to-back.
//
// Optional feature macro: PULSE_STRETCH_QUEUE_EN
//   defined   - strobes during a blink are queued; overflow marks a dropped one
//   undefined - no queue, pending reads 0, any strobe during a blink is dropped
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   pulse_in - event strobe, one event per high cycle
//   led_out  - stretched indicator (registered)
//   busy     - high while a blink or its gap is in progress (registered)
//   pending  - blinks queued but not yet started
//   overflow - sticky, set when an event was dropped; cleared by rst

module pulse_stretcher #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int ON_MS       = 100,
  parameter int OFF_MS      = 100,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int ON_CYC  = (CLK_FREQ / 1000) * ON_MS;
  localparam int OFF_CYC = (CLK_FREQ / 1000) * OFF_MS;
  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  // Timer counts down from ON_CYC-1 / OFF_CYC-1; keep at least one bit.
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYC - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYC - 1);

  if (ON_CYC < 1 || OFF_CYC < 1) begin : g_bad_timing
    $error("pulse_stretcher: on and off durations must each be at least one clock");
  end

  if (MAX_PENDING < 1 || MAX_PENDING > (2 ** PEND_W) - 1) begin : g_bad_depth
    $error("pulse_stretcher: MAX_PENDING must fit in PEND_W bits and be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             active;
  logic             gap_end;
  logic             start_next;

  assign active  = (state != S_IDLE);
  assign gap_end = (state == S_GAP) && (timer == '0);

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  logic [PEND_W-1:0] pend_q;
  logic              take_queued;
  logic              enqueue;

  assign take_queued = gap_end && (pend_q != '0);
  // A strobe landing on the last gap cycle with an empty queue starts the
  // next blink directly instead of being queued.
  assign enqueue     = pulse_in && active && !(gap_end && (pend_q == '0));
  assign start_next  = take_queued || pulse_in;
  assign pending     = pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      overflow <= 1'b0;
    end else if (enqueue && !take_queued) begin
      if (pend_q == PEND_MAX) begin
        overflow <= 1'b1;
      end else begin
        pend_q <= pend_q + PEND_W'(1);
      end
    end else if (take_queued && !enqueue) begin
      pend_q <= pend_q - PEND_W'(1);
    end
    // enqueue together with take_queued cancel: count is unchanged.
  end
`else
  assign start_next = pulse_in;
  assign pending    = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (pulse_in && active && !gap_end) begin
      overflow <= 1'b1;
    end
  end
`endif

  // Outputs are set from the next state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pulse_in) begin
            state   <= S_ON;
            timer   <= ON_LOAD;
            led_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_ON: begin
          if (timer == '0) begin
            state   <= S_GAP;
            timer   <= OFF_LOAD;
            led_out <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_GAP: begin
          if (timer == '0) begin
            if (start_next) begin
              state   <= S_ON;
              timer   <= ON_LOAD;
              led_out <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          timer   <= '0;
          led_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher

module tb_pulse_stretcher;

  localparam int CLK_FREQ    = 1000;
  localparam int ON_MS       = 4;
  localparam int OFF_MS      = 2;
  localparam int MAX_PENDING = 3;
  localparam int PEND_W      = 2;
  localparam int ON_CYC      = (CLK_FREQ / 1000) * ON_MS;
  localparam int OFF_CYC     = (CLK_FREQ / 1000) * OFF_MS;
  localparam int PERIOD      = ON_CYC + OFF_CYC;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pulse_in = 1'b0;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  pulse_stretcher #(
    .CLK_FREQ   (CLK_FREQ),
    .ON_MS      (ON_MS),
    .OFF_MS     (OFF_MS),
    .MAX_PENDING(MAX_PENDING),
    .PEND_W     (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: position inside the current blink window
  // (-1 = no blink, 0..PERIOD-1 = cycle within on-time + gap) plus a count
  // of waiting blinks.
  int m_pos = -1;
  int m_q   = 0;
  bit m_ovf = 1'b0;

  task automatic model_step(input bit r, input bit p);
    if (r) begin
      m_pos = -1;
      m_q   = 0;
      m_ovf = 1'b0;
    end else if (m_pos < 0) begin
      if (p) m_pos = 0;
    end else if (m_pos == PERIOD - 1) begin
      if (QEN && m_q > 0) begin
        m_pos = 0;
        if (!p) m_q--;
      end else begin
        m_pos = p ? 0 : -1;
      end
    end else begin
      m_pos++;
      if (p) begin
        if (QEN && m_q < MAX_PENDING) m_q++;
        else m_ovf = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
  task automatic cyc(input bit r, input bit p);
    rst      = r;
    pulse_in = p;
    @(posedge clk);
    model_step(r, p);
    #1;
  endtask

  // Per-cycle recordings for the hand-written sequences; index = cycle number.
  bit led_a  [0:63];
  bit busy_a [0:63];
  int pend_a [0:63];
  bit ovf_a  [0:63];

  task automatic run_seq(input logic [63:0] pulses, input int ncyc, input int rst_at);
    cyc(1'b1, 1'b0);
    led_a[0] = led_out; busy_a[0] = busy; pend_a[0] = int'(pending); ovf_a[0] = overflow;
    for (int c = 0; c < ncyc; c++) begin
      cyc(c == rst_at, pulses[c]);
      led_a[c+1]  = led_out;
      busy_a[c+1] = busy;
      pend_a[c+1] = int'(pending);
      ovf_a[c+1]  = overflow;
    end
  endtask

  function automatic int rises(input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++)
      if (led_a[c] && !led_a[c-1]) n++;
    return n;
  endfunction

  function automatic int max_pend(input int to);
    int m = 0;
    for (int c = 0; c <= to; c++)
      if (pend_a[c] > m) m = pend_a[c];
    return m;
  endfunction

  typedef struct {
    bit rst;
    bit pulse;
    bit led;
    bit busy;
    int pend;
    bit ovf;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Single blink, then a strobe on the final gap cycle, then mid-blink reset.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].rst, vecs[i].pulse);
      check($sformatf("vec%0d_led", i),  int'(led_out),  int'(vecs[i].led));
      check($sformatf("vec%0d_busy", i), int'(busy),     int'(vecs[i].busy));
      check($sformatf("vec%0d_pend", i), int'(pending),  vecs[i].pend);
      check($sformatf("vec%0d_ovf", i),  int'(overflow), int'(vecs[i].ovf));
    end

    // Strobes at 0, 2, 3.
    run_seq(64'h0D, 24, -1);
    check("t2_pend_c4",   pend_a[4],      QEN ? 2 : 0);
    check("t2_blinks",    rises(1, 24),   QEN ? 3 : 1);
    check("t2_led_c13",   int'(led_a[13]), QEN ? 1 : 0);
    check("t2_busy_c18",  int'(busy_a[18]), QEN ? 1 : 0);
    check("t2_busy_c19",  int'(busy_a[19]), 0);
    check("t2_ovf_c3",    int'(ovf_a[3]),  QEN ? 0 : 1);

    // Strobes on five consecutive cycles.
    run_seq(64'h1F, 40, -1);
    check("t3_pend_c5",   pend_a[5],       QEN ? 3 : 0);
    check("t3_ovf_c4",    int'(ovf_a[4]),  QEN ? 0 : 1);
    check("t3_ovf_c5",    int'(ovf_a[5]),  1);
    check("t3_blinks",    rises(1, 40),    QEN ? 4 : 1);
    check("t3_busy_c24",  int'(busy_a[24]), QEN ? 1 : 0);
    check("t3_busy_c25",  int'(busy_a[25]), 0);

    // Strobes at 0 and 2, reset at cycle 3.
    run_seq(64'h05, 30, 3);
    check("t5_pend_c3",   pend_a[3],       QEN ? 1 : 0);
    check("t5_ovf_c3",    int'(ovf_a[3]),  QEN ? 0 : 1);
    check("t5_led_c4",    int'(led_a[4]),  0);
    check("t5_busy_c4",   int'(busy_a[4]), 0);
    check("t5_pend_c4",   pend_a[4],       0);
    check("t5_ovf_c4",    int'(ovf_a[4]),  0);
    check("t5_no_blinks", rises(5, 30),    0);

    // Strobes at 0 and 2, no reset.
    run_seq(64'h05, 20, -1);
    check("t6_ovf_c2",    int'(ovf_a[2]),  0);
    check("t6_ovf_c3",    int'(ovf_a[3]),  QEN ? 0 : 1);
    check("t6_blinks",    rises(1, 20),    QEN ? 2 : 1);
    check("t6_max_pend",  max_pend(20),    QEN ? 1 : 0);

    // Randomized run against the reference model, alternating dense/sparse strobes.
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      int dens;
      bit r;
      bit p;
      dens = ((i / 250) % 2 == 0) ? 2 : 9;
      r = ($urandom_range(0, 299) == 0);
      p = ($urandom_range(0, dens) == 0);
      cyc(r, p);
      check("rnd_led",  int'(led_out),  (m_pos >= 0 && m_pos < ON_CYC) ? 1 : 0);
      check("rnd_busy", int'(busy),     (m_pos >= 0) ? 1 : 0);
      check("rnd_pend", int'(pending),  m_q);
      check("rnd_ovf",  int'(overflow), int'(m_ovf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
